// File: rtl/wait_memory_pkg.sv
// Shared definitions for the wait-state memory: FSM encoding and widths.
package wait_memory_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int WAIT_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Clamp-free conversion of the wait-state parameter into the counter width
  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_load(input int cycles);
    return WAIT_CNT_WIDTH'(cycles);
  endfunction

endpackage

// File: rtl/wait_memory_array.sv
// Byte-wide storage with per-lane write enables and a combinational
// little-endian word read. Lane addresses wrap at the top of memory.
module wait_memory_array
  import wait_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [BUS_WIDTH/BYTE_WIDTH-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  input  logic [BUS_WIDTH-1:0]           i_wdata,
  output logic [BUS_WIDTH-1:0]           o_rdata
);

  localparam int LANES = BUS_WIDTH / BYTE_WIDTH;

  logic [BYTE_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_lane_addr [LANES];
  logic [LANES-1:0]      w_lane_we;

  // Per-lane byte address (modulo memory size) and lane write enable
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_addr[i] = i_addr + ADDR_WIDTH'(i);
      w_lane_we[i]   = i_we & i_be[i];
    end
  end

  // Assemble the read word from consecutive bytes, lane 0 lowest
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < LANES; i++) begin
      o_rdata[i*BYTE_WIDTH +: BYTE_WIDTH] = r_mem[w_lane_addr[i]];
    end
  end

  // Byte writes; storage intentionally has no reset
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (w_lane_we[i]) begin
        r_mem[w_lane_addr[i]] <= i_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

endmodule

// File: rtl/wait_memory.sv
// Single-port byte memory with a fixed number of wait states per access.
// Optional feature: define WAIT_MEMORY_ALIGN_CHECK_EN to reject accesses
// whose address is not a multiple of the bus width in bytes (ERR=1, RD=0,
// no write). Without it ERR is constantly 0 and unaligned words are allowed.
module wait_memory
  import wait_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int BUS_WIDTH   = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            REQ,
  input  logic                            WE,
  input  logic [BUS_WIDTH/BYTE_WIDTH-1:0] BE,
  input  logic [BUS_WIDTH-1:0]            A,
  input  logic [BUS_WIDTH-1:0]            WD,
  output logic [BUS_WIDTH-1:0]            RD,
  output logic                            READY,
  output logic                            ERR
);

  localparam int LANES = BUS_WIDTH / BYTE_WIDTH;
  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_e                    r_state;
  logic [WAIT_CNT_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic                      r_we;
  logic [LANES-1:0]          r_be;
  logic [BUS_WIDTH-1:0]      r_wdata;

  logic                      w_misalign;
  logic                      w_mem_we;
  logic [BUS_WIDTH-1:0]      w_rdata;

`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
  logic r_misalign;
  logic r_err;
  assign w_misalign = r_misalign;
  assign ERR        = r_err;
`else
  assign w_misalign = 1'b0;
  assign ERR        = 1'b0;
`endif

  // Upper address bits beyond the storage size carry no meaning
  generate
    if (BUS_WIDTH > ADDR_WIDTH) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^A[BUS_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  // The write commits on the response edge, after the old word is read
  assign w_mem_we = (r_state == ST_RESP) & r_we & ~w_misalign;

  wait_memory_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_be    (r_be),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Request capture, wait-state countdown and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      RD         <= '0;
      READY      <= 1'b0;
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
      r_err      <= 1'b0;
`endif
    end else begin
      READY <= 1'b0;
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (REQ) begin
            r_addr  <= A[ADDR_WIDTH-1:0];
            r_we    <= WE;
            r_be    <= BE;
            r_wdata <= WD;
            r_cnt   <= WAIT_LOAD;
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
            r_misalign <= (A[ADDR_WIDTH-1:0] % ADDR_WIDTH'(LANES)) != '0;
`endif
            r_state <= (WAIT_LOAD == '0) ? ST_RESP : ST_WAIT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Leave on the edge where the counter hits zero
          if (r_cnt <= WAIT_CNT_WIDTH'(1)) begin
            r_cnt   <= '0;
            r_state <= ST_RESP;
          end else begin
            r_cnt   <= r_cnt - WAIT_CNT_WIDTH'(1);
          end
        end
        ST_RESP: begin
          READY   <= 1'b1;
          RD      <= w_misalign ? '0 : w_rdata;
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
          r_err   <= w_misalign;
`endif
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_memory.sv
// Self-checking bench for wait_memory: directed scenarios plus random
// accesses checked against a byte-array reference model.
module tb_wait_memory;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int W  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        REQ   = 1'b0;
  logic        WE    = 1'b0;
  logic [3:0]  BE    = 4'h0;
  logic [31:0] A     = 32'h0;
  logic [31:0] WD    = 32'h0;
  logic [31:0] RD;
  logic        READY;
  logic        ERR;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_mem [65536];
  bit         m_vld [65536];

  always #5 clk = ~clk;

  wait_memory #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .REQ(REQ), .WE(WE), .BE(BE), .A(A), .WD(WD),
    .RD(RD), .READY(READY), .ERR(ERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] a);
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Expected word and mask of bytes whose content is known
  task automatic model_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] m);
    logic [15:0] idx;
    d = 32'h0;
    m = 32'h0;
    for (int i = 0; i < 4; i++) begin
      idx = a[15:0] + 16'(i);
      if (m_vld[idx]) begin
        d[8*i +: 8] = m_mem[idx];
        m[8*i +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [15:0] idx;
    for (int i = 0; i < 4; i++) begin
      idx = a[15:0] + 16'(i);
      if (be[i]) begin
        m_mem[idx] = wd[8*i +: 8];
        m_vld[idx] = 1'b1;
      end
    end
  endtask

  // One isolated access: latency, data, error and single-cycle READY
  task automatic access(input string tag, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_o);
    logic [31:0] ed, em;
    bit ee, got;
    int lat;
    ee = misaligned(a);
    if (ee) begin
      ed = 32'h0;
      em = 32'hFFFF_FFFF;
    end else begin
      model_read(a, ed, em);
      if (we) model_write(a, be, wd);
    end
    @(negedge clk);
    REQ = 1'b1; WE = we; BE = be; A = a; WD = wd;
    @(posedge clk); #1;
    REQ = 1'b0; WE = 1'b0; BE = 4'h0; A = 32'h0; WD = 32'h0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (READY === 1'b1) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(W + 1));
    rd_o = RD;
    check({tag, "_rd"}, RD & em, ed);
    check({tag, "_err"}, {31'h0, ERR}, {31'h0, ee});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'h0, READY}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd, ed, em;
    int n, pulses;
    int exp_k [4];
    logic [31:0] b2b_addr [4];
    logic [31:0] ra;

    for (int i = 0; i < 65536; i++) m_vld[i] = 1'b0;

    // Reset state
    #2;
    check("rst_rd", RD, 32'h0);
    check("rst_ready", {31'h0, READY}, 32'h0);
    check("rst_err", {31'h0, ERR}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read back
    access("wr10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd);
    access("rd10", 1'b0, 4'h0, 32'h10, 32'h0, rd);
    check("rd10_val", rd, 32'hDEADBEEF);

    // Partial-lane write; write returns the pre-write word
    access("wr20", 1'b1, 4'hF, 32'h20, 32'h11223344, rd);
    access("wr20be", 1'b1, 4'h2, 32'h20, 32'h0000AA00, rd);
    check("wr20be_old", rd, 32'h11223344);
    access("rd20", 1'b0, 4'hF, 32'h20, 32'h0, rd);
    check("rd20_val", rd, 32'h1122AA44);

    // REQ held high: one READY per W+2 cycles, intermediate requests dropped
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h20; b2b_addr[2] = 32'h10; b2b_addr[3] = 32'h20;
    for (int j = 0; j < 4; j++) exp_k[j] = j * (W + 2) + W + 1;
    n = 0;
    @(negedge clk);
    REQ = 1'b1; WE = 1'b0; BE = 4'h0;
    for (int k = 0; k < 4 * (W + 2); k++) begin
      A = (k % (W + 2) == 0) ? b2b_addr[k / (W + 2)] : 32'h30;
      @(posedge clk); #1;
      if (READY === 1'b1) begin
        if (n < 4) begin
          model_read(b2b_addr[n], ed, em);
          check("b2b_cycle", 32'(k), 32'(exp_k[n]));
          check("b2b_rd", RD & em, ed);
        end
        n++;
      end
      @(negedge clk);
    end
    REQ = 1'b0;
    A = 32'h0;
    check("b2b_count", 32'(n), 32'd4);

    // Unaligned write: rejected with the check, straddling bytes without it
    access("wr22", 1'b1, 4'hF, 32'h22, 32'hA1B2C3D4, rd);
    access("rd20b", 1'b0, 4'h0, 32'h20, 32'h0, rd);
`ifdef WAIT_MEMORY_ALIGN_CHECK_EN
    check("rd20b_val", rd, 32'h1122AA44);
`else
    check("rd20b_val", rd, 32'hC3D4AA44);
    access("rd24", 1'b0, 4'h0, 32'h24, 32'h0, rd);
    check("rd24_lo", rd & 32'h0000FFFF, 32'h0000A1B2);
`endif

    // Reset during WAIT aborts the write and suppresses READY
    access("wr30", 1'b1, 4'hF, 32'h30, 32'h55667788, rd);
    @(negedge clk);
    REQ = 1'b1; WE = 1'b1; BE = 4'hF; A = 32'h30; WD = 32'hFFFFFFFF;
    @(posedge clk); #1;
    REQ = 1'b0; WE = 1'b0; BE = 4'h0; A = 32'h0; WD = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_rd", RD, 32'h0);
    check("abort_ready", {31'h0, READY}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (READY === 1'b1) pulses++;
    end
    check("abort_noready", 32'(pulses), 32'h0);
    access("rd30", 1'b0, 4'h0, 32'h30, 32'h0, rd);
    check("rd30_val", rd, 32'h55667788);

`ifndef WAIT_MEMORY_ALIGN_CHECK_EN
    // Word straddling the top of memory wraps to address 0
    access("wrtop", 1'b1, 4'hF, 32'hFFFE, 32'hCAFEF00D, rd);
    access("rdtop", 1'b0, 4'h0, 32'hFFFE, 32'h0, rd);
    check("rdtop_val", rd, 32'hCAFEF00D);
    access("rd0", 1'b0, 4'h0, 32'h0, 32'h0, rd);
    check("rd0_lo", rd & 32'h0000FFFF, 32'h0000CAFE);
`endif

    // Random accesses against the reference model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 1) == 0) ra = 32'h100 + 32'($urandom_range(0, 31));
      else ra = 32'hFFF0 + 32'($urandom_range(0, 15));
      access("rand", 1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
